// File: rtl/vm80a_pkg.sv
// Shared definitions for the vm80a system controller: status bit positions,
// cycle FSM encoding, strobe bundle and interrupt vector opcodes.
package vm80a_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 2;

    localparam int unsigned ST_INTA  = 0;
    localparam int unsigned ST_WO_N  = 1;
    localparam int unsigned ST_STACK = 2;
    localparam int unsigned ST_HLTA  = 3;
    localparam int unsigned ST_OUT   = 4;
    localparam int unsigned ST_M1    = 5;
    localparam int unsigned ST_INP   = 6;
    localparam int unsigned ST_MEMR  = 7;

    localparam logic [DATA_W-1:0] OP_CALL = 8'hCD;
    localparam logic [DATA_W-1:0] OP_RST7 = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_ACK  = 2'd3
    } state_e;

    typedef struct packed {
        logic memr_n;
        logic memw_n;
        logic ior_n;
        logic iow_n;
        logic inta_n;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '1;

    // At most one strobe low; memory read outranks I/O read on odd statuses.
    function automatic strobes_t decode_strobes(input state_e st, input logic [DATA_W-1:0] s);
        strobes_t r;
        r = STROBES_IDLE;
        case (st)
            S_RD: begin
                if (s[ST_MEMR]) begin
                    r.memr_n = 1'b0;
                end else if (s[ST_INP]) begin
                    r.ior_n = 1'b0;
                end
            end
            S_ACK: r.inta_n = 1'b0;
            S_WR: begin
                if (s[ST_OUT]) begin
                    r.iow_n = 1'b0;
                end else begin
                    r.memw_n = 1'b0;
                end
            end
            default: r = STROBES_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vm80a_ackvec.sv
// Interrupt-acknowledge byte sequencer: tracks which vector byte the core
// reads next and muxes the matching RST or CALL byte.
module vm80a_ackvec
    import vm80a_pkg::*;
#(
    parameter logic [DATA_W-1:0] RST_VEC   = 8'hE7,
    parameter bit                CALL_MODE = 1'b0,
    parameter logic [15:0]       CALL_ADDR = 16'h0038
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [DATA_W-1:0] vec_c
);

    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    logic [IDX_W-1:0] idx_q;

    // Saturates at the last slot so stray extra reads see OP_RST7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (clr) begin
            idx_q <= '0;
        end else if (inc && (idx_q != IDX_LAST)) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        vec_c = RST_VEC;
        if (CALL_MODE) begin
            case (idx_q)
                2'd0:    vec_c = OP_CALL;
                2'd1:    vec_c = CALL_ADDR[7:0];
                2'd2:    vec_c = CALL_ADDR[15:8];
                default: vec_c = OP_RST7;
            endcase
        end
    end

endmodule

// File: rtl/vm80a_sysctl.sv
// 8228-class system controller: latches the SYNC status byte, decodes bus
// strobes, and supplies interrupt-acknowledge vectors on the core data bus.
module vm80a_sysctl
    import vm80a_pkg::*;
#(
    parameter logic [DATA_W-1:0] RST_VEC   = 8'hE7,
    parameter bit                CALL_MODE = 1'b0,
    parameter logic [15:0]       CALL_ADDR = 16'h0038
) (
    input  logic              pin_clk,
    input  logic              pin_reset_n,
    inout  wire  [DATA_W-1:0] pin_d,
    input  logic              pin_sync,
    input  logic              pin_dbin,
    input  logic              pin_wr_n,
    input  logic              pin_hlda,
    output logic [DATA_W-1:0] status,
    output logic              memr_n,
    output logic              memw_n,
    output logic              ior_n,
    output logic              iow_n,
    output logic              inta_n,
    output logic              busen_n
);

    logic [DATA_W-1:0] status_q;
    state_e            state_q;
    state_e            state_d;
    strobes_t          strb_q;
    strobes_t          strb_d;
    logic              busen_q;
    logic              busen_d;
    logic              ack_clr;
    logic              ack_inc;
    logic              drive_c;
    logic [DATA_W-1:0] vec_c;

    // Status capture continues during HLDA so the next cycle decodes correctly.
    always_ff @(posedge pin_clk or negedge pin_reset_n) begin
        if (!pin_reset_n) begin
            status_q <= '0;
        end else if (pin_sync) begin
            status_q <= pin_d;
        end
    end

    always_ff @(posedge pin_clk or negedge pin_reset_n) begin
        if (!pin_reset_n) begin
            state_q <= S_IDLE;
            strb_q  <= STROBES_IDLE;
            busen_q <= 1'b1;
        end else begin
            state_q <= state_d;
            strb_q  <= strb_d;
            busen_q <= busen_d;
        end
    end

    // Write outranks read if the core ever raises both at once.
    always_comb begin
        state_d = state_q;
        strb_d  = decode_strobes(state_q, status_q);
        busen_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (!pin_wr_n) begin
                    state_d = S_WR;
                end else if (pin_dbin) begin
                    state_d = status_q[ST_INTA] ? S_ACK : S_RD;
                end
            end
            S_RD, S_ACK: begin
                if (!pin_dbin) begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                if (pin_wr_n) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pin_hlda) begin
            state_d = S_IDLE;
            strb_d  = STROBES_IDLE;
        end

        if (((state_d == S_RD) || (state_d == S_WR)) && !status_q[ST_INTA]) begin
            busen_d = 1'b0;
        end
    end

    // A fresh M1+INTA status restarts the vector sequence at its first byte.
    assign ack_clr = pin_sync && pin_d[ST_M1] && pin_d[ST_INTA];
    assign ack_inc = (state_q == S_ACK) && (state_d != S_ACK);

    vm80a_ackvec #(
        .RST_VEC   (RST_VEC),
        .CALL_MODE (CALL_MODE),
        .CALL_ADDR (CALL_ADDR)
    ) u_ackvec (
        .clk   (pin_clk),
        .rst_n (pin_reset_n),
        .clr   (ack_clr),
        .inc   (ack_inc),
        .vec_c (vec_c)
    );

    assign drive_c = pin_dbin && status_q[ST_INTA] && !pin_hlda;
    assign pin_d   = drive_c ? vec_c : {DATA_W{1'bz}};

    assign status  = status_q;
    assign memr_n  = strb_q.memr_n;
    assign memw_n  = strb_q.memw_n;
    assign ior_n   = strb_q.ior_n;
    assign iow_n   = strb_q.iow_n;
    assign inta_n  = strb_q.inta_n;
    assign busen_n = busen_q;

endmodule

// File: tb/tb_vm80a_sysctl.sv
// Scoreboard bench for vm80a_sysctl: one RST-mode and one CALL-mode instance
// share the same bus-cycle stimulus; expected outputs are queued per cycle.
module tb_vm80a_sysctl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync = 1'b0;
    logic       dbin = 1'b0;
    logic       wr_n = 1'b1;
    logic       hlda = 1'b0;
    logic [7:0] d_tb = 8'h00;

    wire  [7:0] bus0;
    wire  [7:0] bus1;
    logic [7:0] st0, st1;
    logic       memr0, memw0, ior0, iow0, inta0, busen0;
    logic       memr1, memw1, ior1, iow1, inta1, busen1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [7:0] status;
        logic [4:0] strb;
        logic       busen;
        logic       drv;
        logic [7:0] v0;
        logic [7:0] v1;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [4:0] I  = 5'b11111;
    localparam logic [4:0] MR = 5'b01111;
    localparam logic [4:0] MW = 5'b10111;
    localparam logic [4:0] IR = 5'b11011;
    localparam logic [4:0] IW = 5'b11101;
    localparam logic [4:0] IA = 5'b11110;

    always #5 clk = ~clk;

    assign bus0 = sync ? d_tb : 8'bzzzz_zzzz;
    assign bus1 = sync ? d_tb : 8'bzzzz_zzzz;

    vm80a_sysctl #(.RST_VEC(8'hE7), .CALL_MODE(1'b0), .CALL_ADDR(16'h0038)) u0 (
        .pin_clk(clk), .pin_reset_n(rst_n), .pin_d(bus0), .pin_sync(sync),
        .pin_dbin(dbin), .pin_wr_n(wr_n), .pin_hlda(hlda), .status(st0),
        .memr_n(memr0), .memw_n(memw0), .ior_n(ior0), .iow_n(iow0),
        .inta_n(inta0), .busen_n(busen0)
    );

    vm80a_sysctl #(.RST_VEC(8'hE7), .CALL_MODE(1'b1), .CALL_ADDR(16'h1234)) u1 (
        .pin_clk(clk), .pin_reset_n(rst_n), .pin_d(bus1), .pin_sync(sync),
        .pin_dbin(dbin), .pin_wr_n(wr_n), .pin_hlda(hlda), .status(st1),
        .memr_n(memr1), .memw_n(memw1), .ior_n(ior1), .iow_n(iow1),
        .inta_n(inta1), .busen_n(busen1)
    );

    task automatic chk(input string nm, input string what, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%02h required=%02h", nm, what, act, req);
        end
    endtask

    // Monitor: outputs settle after each rising edge; compare against the queued cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "status0", st0, e.status);
                chk(e.name, "status1", st1, e.status);
                chk(e.name, "strb0", {3'b000, memr0, memw0, ior0, iow0, inta0}, {3'b000, e.strb});
                chk(e.name, "strb1", {3'b000, memr1, memw1, ior1, iow1, inta1}, {3'b000, e.strb});
                chk(e.name, "busen0", {7'd0, busen0}, {7'd0, e.busen});
                chk(e.name, "busen1", {7'd0, busen1}, {7'd0, e.busen});
                if (e.drv) begin
                    chk(e.name, "vec0", bus0, e.v0);
                    chk(e.name, "vec1", bus1, e.v1);
                end
            end
        end
    end

    // One bus clock of stimulus plus the outputs expected after the following edge.
    task automatic cyc(input string nm, input logic r, input logic s, input logic db,
                       input logic w, input logic h, input logic [7:0] d,
                       input logic [7:0] est, input logic [4:0] estr, input logic ebus,
                       input logic edrv, input logic [7:0] e0, input logic [7:0] e1);
        exp_t e;
        @(negedge clk);
        rst_n = r; sync = s; dbin = db; wr_n = w; hlda = h; d_tb = d;
        e.name = nm; e.status = est; e.strb = estr; e.busen = ebus;
        e.drv = edrv; e.v0 = e0; e.v1 = e1;
        exp_q.push_back(e);
    endtask

    // SYNC status then a single-clock ack read; v1 is the CALL-mode byte.
    task automatic ack_read(input string nm, input logic [7:0] st, input logic [7:0] v1);
        cyc({nm, "_sync"}, 1, 1, 0, 1, 0, st, st, I,  1, 0, 8'h00, 8'h00);
        cyc({nm, "_rd"},   1, 0, 1, 1, 0, 0,  st, I,  1, 1, 8'hE7, v1);
        cyc({nm, "_end"},  1, 0, 0, 1, 0, 0,  st, IA, 1, 0, 8'h00, 8'h00);
        cyc({nm, "_idle"}, 1, 0, 0, 1, 0, 0,  st, I,  1, 0, 8'h00, 8'h00);
    endtask

    initial begin
        int wait_cnt;
        // reset state
        cyc("rst_a", 0, 0, 0, 1, 0, 8'h00, 8'h00, I, 1, 0, 0, 0);
        cyc("rst_b", 0, 0, 0, 1, 0, 8'h00, 8'h00, I, 1, 0, 0, 0);

        // opcode fetch, DBIN 4 clocks
        cyc("fetch_sync", 1, 1, 0, 1, 0, 8'hA2, 8'hA2, I,  1, 0, 0, 0);
        cyc("fetch_rd0",  1, 0, 1, 1, 0, 8'h00, 8'hA2, I,  0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("fetch_rd",  1, 0, 1, 1, 0, 8'h00, 8'hA2, MR, 0, 0, 0, 0);
        cyc("fetch_end",  1, 0, 0, 1, 0, 8'h00, 8'hA2, MR, 1, 0, 0, 0);
        cyc("fetch_idle", 1, 0, 0, 1, 0, 8'h00, 8'hA2, I,  1, 0, 0, 0);

        // memory write
        cyc("mw_sync", 1, 1, 0, 1, 0, 8'h00, 8'h00, I,  1, 0, 0, 0);
        cyc("mw_wr",   1, 0, 0, 0, 0, 8'h00, 8'h00, I,  0, 0, 0, 0);
        cyc("mw_end",  1, 0, 0, 1, 0, 8'h00, 8'h00, MW, 1, 0, 0, 0);
        cyc("mw_idle", 1, 0, 0, 1, 0, 8'h00, 8'h00, I,  1, 0, 0, 0);

        // I/O write, WR_n 3 clocks
        cyc("iow_sync", 1, 1, 0, 1, 0, 8'h10, 8'h10, I,  1, 0, 0, 0);
        cyc("iow_wr0",  1, 0, 0, 0, 0, 8'h00, 8'h10, I,  0, 0, 0, 0);
        cyc("iow_wr1",  1, 0, 0, 0, 0, 8'h00, 8'h10, IW, 0, 0, 0, 0);
        cyc("iow_wr2",  1, 0, 0, 0, 0, 8'h00, 8'h10, IW, 0, 0, 0, 0);
        cyc("iow_end",  1, 0, 0, 1, 0, 8'h00, 8'h10, IW, 1, 0, 0, 0);
        cyc("iow_idle", 1, 0, 0, 1, 0, 8'h00, 8'h10, I,  1, 0, 0, 0);

        // invalid status 00 in a read: no strobe
        cyc("inv_sync", 1, 1, 0, 1, 0, 8'h00, 8'h00, I, 1, 0, 0, 0);
        cyc("inv_rd",   1, 0, 1, 1, 0, 8'h00, 8'h00, I, 0, 0, 0, 0);
        cyc("inv_end",  1, 0, 0, 1, 0, 8'h00, 8'h00, I, 1, 0, 0, 0);

        // DBIN and WR_n together: write wins
        cyc("both_sync", 1, 1, 0, 1, 0, 8'h10, 8'h10, I,  1, 0, 0, 0);
        cyc("both_cyc",  1, 0, 1, 0, 0, 8'h00, 8'h10, I,  0, 0, 0, 0);
        cyc("both_end",  1, 0, 0, 1, 0, 8'h00, 8'h10, IW, 1, 0, 0, 0);
        cyc("both_idle", 1, 0, 0, 1, 0, 8'h00, 8'h10, I,  1, 0, 0, 0);

        // HLDA mid memory read; status still captured during hold
        cyc("hl_sync",  1, 1, 0, 1, 0, 8'h82, 8'h82, I,  1, 0, 0, 0);
        cyc("hl_rd0",   1, 0, 1, 1, 0, 8'h00, 8'h82, I,  0, 0, 0, 0);
        cyc("hl_rd1",   1, 0, 1, 1, 0, 8'h00, 8'h82, MR, 0, 0, 0, 0);
        cyc("hl_hold",  1, 0, 1, 1, 1, 8'h00, 8'h82, I,  1, 0, 0, 0);
        cyc("hl_cap",   1, 1, 0, 1, 1, 8'h42, 8'h42, I,  1, 0, 0, 0);
        cyc("hl_drop",  1, 0, 0, 1, 0, 8'h00, 8'h42, I,  1, 0, 0, 0);
        cyc("hl_ior0",  1, 0, 1, 1, 0, 8'h00, 8'h42, I,  0, 0, 0, 0);
        cyc("hl_ior1",  1, 0, 0, 1, 0, 8'h00, 8'h42, IR, 1, 0, 0, 0);
        cyc("hl_idle",  1, 0, 0, 1, 0, 8'h00, 8'h42, I,  1, 0, 0, 0);

        // interrupt: two-clock ack read, then CALL sequence continues
        cyc("int_sync", 1, 1, 0, 1, 0, 8'h23, 8'h23, I,  1, 0, 0, 0);
        cyc("int_rd0",  1, 0, 1, 1, 0, 8'h00, 8'h23, I,  1, 1, 8'hE7, 8'hCD);
        cyc("int_rd1",  1, 0, 1, 1, 0, 8'h00, 8'h23, IA, 1, 1, 8'hE7, 8'hCD);
        cyc("int_end",  1, 0, 0, 1, 0, 8'h00, 8'h23, IA, 1, 0, 0, 0);
        cyc("int_idle", 1, 0, 0, 1, 0, 8'h00, 8'h23, I,  1, 0, 0, 0);
        ack_read("call_lo",  8'h03, 8'h34);
        ack_read("call_hi",  8'h03, 8'h12);
        ack_read("call_ovr", 8'h03, 8'hFF);
        ack_read("call_new", 8'h23, 8'hCD);

        // reset during ack byte 1
        cyc("ra_sync", 1, 1, 0, 1, 0, 8'h03, 8'h03, I, 1, 0, 0, 0);
        cyc("ra_rd",   1, 0, 1, 1, 0, 8'h00, 8'h03, I, 1, 1, 8'hE7, 8'h34);
        cyc("ra_rst",  0, 0, 1, 1, 0, 8'h00, 8'h00, I, 1, 0, 0, 0);
        cyc("ra_rel",  1, 0, 0, 1, 0, 8'h00, 8'h00, I, 1, 0, 0, 0);
        ack_read("ra_after", 8'h03, 8'hCD);

        // HLTA with INTA treated as ack
        ack_read("hlta", 8'h2B, 8'hCD);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
